// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver: synchronised rx, small byte FIFO, STATUS/DATA words.
// Optional even-parity frame check is enabled by defining UART_RX_PARITY_EN.
module uart_rx_mmio #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] DATA_ADDR    = 32'h0000_03f0,
  parameter logic [31:0] STAT_ADDR    = 32'h0000_03f4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  input  logic [31:0] rw_addr,
  input  logic        r_en,
  input  logic        w_en,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  output logic        irq,
  output logic [2:0]  state_o
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = AW + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BRK    = 3'd5
  } state_e;

  // Handshake: the CPU bus has no ready; a load of DATA_ADDR with r_en high is a
  // pop accepted at that posedge when non-empty, and r_data is valid every cycle.
  state_e          state_q, state_d;
  logic            sync1_q, rx_s_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            push_req, ferr_set;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q;
  logic            ovr_q, ferr_q, irq_q;
  logic            perr_q, par_bad_q;

  logic            nonempty, full, do_pop, do_push, ovr_set, clr_wr;

`ifdef UART_RX_PARITY_EN
  logic par_bad_d, perr_set;
  logic unused_w_data;
  assign unused_w_data = ^{w_data[31:4], w_data[0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
    end else begin
      perr_q    <= perr_set | (perr_q & ~(clr_wr & w_data[3]));
      par_bad_q <= par_bad_d;
    end
  end
`else
  logic unused_w_data;
  assign unused_w_data = ^{w_data[31:3], w_data[0]};
  assign perr_q        = 1'b0;
  assign par_bad_q     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    push_req = 1'b0;
    ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_set  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = rx_s_q ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (idx_q == 3'd7) state_d = PARITY;
`else
          if (idx_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          if (rx_s_q != ^shift_q) begin
            perr_set  = 1'b1;
            par_bad_d = 1'b1;
          end
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          if (rx_s_q) begin
            push_req = ~par_bad_q;
            state_d  = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = BRK;
          end
        end
      end
      BRK: begin
        // Hold off until the line is released so a stuck-low rx cannot retrigger.
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign nonempty = (count_q != '0);
  assign full     = (count_q == CNT_FULL);
  assign do_pop   = r_en && (rw_addr == DATA_ADDR) && nonempty;
  assign clr_wr   = w_en && (rw_addr == STAT_ADDR);
  // A same-cycle pop frees the slot the incoming byte needs.
  assign do_push  = push_req && (!full || do_pop);
  assign ovr_set  = push_req && full && !do_pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      rx_s_q   <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
      ovr_q  <= ovr_set  | (ovr_q  & ~(clr_wr & w_data[1]));
      ferr_q <= ferr_set | (ferr_q & ~(clr_wr & w_data[2]));
      irq_q  <= nonempty | ovr_q | ferr_q | perr_q;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  // The count field is 4 bits wide; at depth 16 a full FIFO is signalled by bit 8.
  always_comb begin
    r_data = '0;
    if (rw_addr == DATA_ADDR) begin
      if (nonempty) r_data[7:0] = mem_q[rd_ptr_q];
    end else if (rw_addr == STAT_ADDR) begin
      r_data[0]   = nonempty;
      r_data[1]   = ovr_q;
      r_data[2]   = ferr_q;
      r_data[3]   = perr_q;
      r_data[7:4] = 4'(count_q);
      r_data[8]   = full;
    end
  end

  assign irq     = irq_q;
  assign state_o = state_q;

endmodule

// File: doc/uart_rx_mmio.md
Name: uart_rx_mmio

Overview:
- Memory-mapped UART receiver peripheral on the CPU data-memory bus. It is the input-direction counterpart to the LED8 output peripheral.
- Deserialises 8N1 frames from an external `rx` pin into a small FIFO.
- The CPU polls a STATUS word and pops bytes from a DATA word.
- `r_data` is combinational so the top-level read mux can select it alongside data_mem.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; must be >= 4 and even.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, 2..16.
- DATA_ADDR, 32'h0000_03f0, read-pop address.
- STAT_ADDR, 32'h0000_03f4, status read / write-1-to-clear address.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input, idle high.
- rw_addr  in  32  CPU data address.
- r_en  in  1  CPU load strobe for this cycle.
- w_en  in  1  CPU store strobe.
- w_data  in  32  CPU store data.
- r_data  out  32  combinational read data.
- irq  out  1  registered; high while FIFO non-empty or any error flag is set.

Behaviour:
- Reset values:
  - FIFO empty, pointers and count 0.
  - Error flags 0, irq 0, FSM in IDLE.
  - Synchroniser flops 1.
  - r_data follows the combinational rules below (STATUS reads 0 after reset).
- rx passes through a 2-flop synchroniser; the FSM uses only the synchronised value `rx_s`.
- Bit counter counts 0..CLKS_PER_BIT-1, then wraps.
- FSM states:
  - IDLE: `rx_s==0` -> START, counter cleared.
  - START: at count CLKS_PER_BIT/2-1:
    - if `rx_s==0`, go to DATA with counter cleared and bit index 0;
    - else (glitch) go back to IDLE.
  - DATA: every CLKS_PER_BIT cycles, sample `rx_s` into shift bit[idx], LSB first. After idx 7 -> STOP (or PARITY if the option is enabled).
  - STOP: after CLKS_PER_BIT cycles, sample `rx_s`:
    - 1: push byte into FIFO, or, if the FIFO is full, drop the byte and set `ovr`; then -> IDLE.
    - 0: set `ferr`, drop the byte, -> BRK.
  - BRK: stay until `rx_s==1`, then -> IDLE. This prevents a stuck-low line from retriggering.
- Read map (r_data, combinational, independent of r_en):
  - `rw_addr==DATA_ADDR`: {24'b0, FIFO head}, or 0 when empty.
  - `rw_addr==STAT_ADDR`: bit0 nonempty, bit1 ovr, bit2 ferr, bit3 perr, bits[7:4] count, bit8 full, other bits 0.
  - Any other address: 0.
- Pop: at posedge when `r_en && rw_addr==DATA_ADDR` and the FIFO is non-empty. Pop on empty has no effect.
- Clear: at posedge when `w_en && rw_addr==STAT_ADDR`:
  - `w_data[1]` clears ovr, `w_data[2]` clears ferr, `w_data[3]` clears perr.
  - If an error set and a clear land in the same cycle, set wins.
- Writes to DATA_ADDR are ignored.
- Push and pop in the same cycle:
  - Both take effect and count is unchanged.
  - When full, the simultaneous pop frees a slot, so the push succeeds and ovr is not set.
- irq = registered OR of nonempty/ovr/ferr/perr. It lags the state change by one cycle.
- Reset mid-frame: the partial byte is discarded and the FSM returns to IDLE immediately.
- Pointers wrap modulo FIFO_DEPTH. count spans 0..FIFO_DEPTH.

Optional Feature:
- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - A PARITY state is inserted between DATA and STOP and samples one even-parity bit.
  - On mismatch, perr is set and the byte is dropped at STOP, even if the stop bit is good.
- Undefined:
  - No PARITY state; frames are 8N1.
  - STATUS bit3 reads constant 0 and the clear write to it is ignored.

Test Plan:
1. Reset, then send 0xA5 at CLKS_PER_BIT=16 -> STATUS reads 0x11 and irq goes high. Load DATA -> 0xA5, next STATUS = 0x00, and irq low one cycle later.
2. Send 0x01, 0x02, 0x03, 0x04, 0x05 with no reads (FIFO_DEPTH=4) -> STATUS = 0x143 (count 4, full, ovr, nonempty). Pops return 01, 02, 03, 04. Store 0x2 to STAT_ADDR -> ovr clears.
3. Drive rx low for 5 cycles, then high -> no byte pushed; FSM back in IDLE; STATUS = 0.
4. Frame 0x3C with stop bit 0, then line held low for 40 cycles, then high, then frame 0x7E -> ferr set. Only 0x7E is in the FIFO (no spurious 0x00 bytes).
5. FIFO full; the stop-bit sample of a fifth byte coincides with a DATA pop -> count stays 4, ovr stays 0, and the new byte is at the tail.
6. Assert reset during bit 4 of a frame -> FIFO empty, flags 0. A following clean 0x55 frame is received correctly. With `UART_RX_PARITY_EN`: 0x55 with parity bit 1 -> perr=1 and no push.
